slot_burst_initiator: RTL and testbench
=======================================

// Module: slot_burst_initiator
// PURPOSE
//  Bus initiator for the 5-bit-address / 32-bit-data MMIO slot interface (cs/read/write/addr/wr_data/rd_data).
//  Turns one command (base, length, direction) into a burst of single-cycle slot writes fed from a valid/ready
//  input stream, or a burst of pipelined slot reads returned on an output stream.
//  Sits between a processor-side command register file or test harness and any slot responder, e.g. the slot RAM core.
// PARAMETERS
//  ADDR_W      5   slot address width; addresses wrap modulo 2**ADDR_W
//  DATA_W      32  slot data width
//  RD_LATENCY  2   cycles from cs&read visible on slot to valid rd_data (slot RAM core = 2)
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  reset       in   1          synchronous, active-high
//  cmd_start   in   1          1-cycle command strobe; sampled only in IDLE
//  cmd_write   in   1          1 = write burst, 0 = read burst
//  cmd_base    in   ADDR_W     first slot address
//  cmd_len     in   ADDR_W+1   word count, 0..2**ADDR_W
//  busy        out  1          high from cycle after accepted cmd_start until done pulse inclusive
//  done        out  1          1-cycle pulse, burst complete
//  wdat        in   DATA_W     write-stream data
//  wdat_valid  in   1          write-stream valid
//  wdat_ready  out  1          write-stream ready; transfer = valid & ready
//  rdat        out  DATA_W     read-stream data
//  rdat_valid  out  1          1-cycle pulse per word; no backpressure, consumer must accept
//  cs          out  1          slot select
//  read        out  1          slot read strobe
//  write       out  1          slot write strobe
//  addr        out  ADDR_W     slot address
//  wr_data     out  DATA_W     slot write data
//  rd_data     in   DATA_W     slot read data
// BEHAVIOUR
//  Reset: state IDLE; cs, read, write, busy, done, wdat_ready, rdat_valid = 0; addr, wr_data, rdat = 0.
//  Read pipeline cleared on reset.
//  All outputs are registered, except wdat_ready, which is a decode of state and remaining count.
//  FSM IDLE -> (cmd_start) WR_BURST | RD_ISSUE | DONE (if cmd_len==0).
//  Latch base into address counter; latch len into remaining counter.
//  WR_BURST:
//   - wdat_ready = 1 while remaining != 0.
//   - On each transfer, the next cycle shows cs=1, write=1, addr=current, wr_data=wdat; then addr+1 (wraps 31->0) and remaining-1.
//   - No transfer: cs=write=0 that cycle (idle bubble, never a repeated write).
//   - remaining hits 0 -> DONE.
//  RD_ISSUE:
//   - One read per cycle, back-to-back: cs=1, read=1, addr incrementing with wrap, remaining-1.
//   - After the last issue -> RD_DRAIN.
//   - A RD_LATENCY-deep valid shift register tracks outstanding reads.
//  Read capture: a read visible on the slot in cycle T is sampled from rd_data at the end of cycle T+RD_LATENCY.
//   rdat/rdat_valid are presented in cycle T+RD_LATENCY+1. Data returns in issue order.
//  RD_DRAIN: wait until the shift register is empty (last rdat_valid seen), then -> DONE.
//  DONE: done=1 for one cycle, busy=1 that cycle; -> IDLE. busy=0 in IDLE.
//  cs is never high with both read and write; read/write never high without cs.
//  cmd_start while not IDLE is ignored (no queuing). cmd_start in the DONE cycle is also ignored.
//  cmd_len==0: no slot activity; done pulses 2 cycles after cmd_start.
//  cmd_len==32: full wrap, final address = base-1 mod 32.
//  Reset mid-burst: per the reset list above; pending reads are dropped (no rdat_valid, no done).
// TESTING
//  1 Write burst: base=3, len=4, wdat=A0..A3 valid every cycle -> slot writes on consecutive cycles at addr 3,4,5,6
//    with A0..A3; done once; busy low afterwards.
//  2 Stalled writes: base=30, len=4, valid toggling 1,0,1,1,0,1 -> exactly 4 writes at addr 30,31,0,1.
//    No write in gap cycles; wrap verified.
//  3 Read burst against the slot RAM model (RD_LATENCY=2): preload mem[3..6], read base=3, len=4 ->
//    4 consecutive rdat_valid pulses, the first 3 cycles after the first read strobe, data in order; done after the last.
//  4 Edge lengths: len=0 -> done 2 cycles after start, cs never high.
//    len=32 read from base=5 -> 32 reads, addr 5..31,0..4, 32 rdat.
//  5 Ignored command: cmd_start pulsed mid-burst with different base -> no effect, original burst completes unchanged.
//  6 Reset at 2nd of 4 outstanding reads -> next cycle cs=0, busy=0; no further rdat_valid or done.
//    A new 1-word write afterwards completes normally.

Source files
------------

// File: rtl/slot_burst_initiator_if.sv
// Command, write/read stream and MMIO slot signals of the burst initiator.
// master = initiator side, slave = harness/responder side.
interface slot_burst_initiator_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cmd_start;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] wdat;
    logic              wdat_valid;
    logic              wdat_ready;
    logic [DATA_W-1:0] rdat;
    logic              rdat_valid;
    logic              cs;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  cmd_start, cmd_write, cmd_base, cmd_len, wdat, wdat_valid, rd_data,
        output busy, done, wdat_ready, rdat, rdat_valid, cs, read, write, addr, wr_data
    );

    modport slave (
        output cmd_start, cmd_write, cmd_base, cmd_len, wdat, wdat_valid, rd_data,
        input  busy, done, wdat_ready, rdat, rdat_valid, cs, read, write, addr, wr_data
    );
endinterface

// File: rtl/slot_burst_initiator.sv
// Turns one (base, len, dir) command into a burst of slot writes fed by a valid/ready stream,
// or pipelined slot reads returned as rdat pulses (RD_LATENCY+1 cycles after each read strobe).
module slot_burst_initiator #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    slot_burst_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_BURST, RD_ISSUE, RD_DRAIN, DONE} state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     ptr_q;
    logic [ADDR_W:0]       rem_q;
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic                  cs_q;
    logic                  read_q;
    logic                  write_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rdat_valid_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic [DATA_W-1:0]     rdat_q;

    logic wr_rdy;
    logic wr_xfer;
    logic last_word;

    assign wr_rdy    = (state_q == WR_BURST) && (rem_q != '0);
    assign wr_xfer   = wr_rdy && bus.wdat_valid;
    assign last_word = (rem_q == (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            rd_pipe_q    <= '0;
            cs_q         <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdat_valid_q <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            rdat_q       <= '0;
        end else begin
            cs_q    <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;

            // bit k set: a read that was on the slot k+1 cycles ago; the top bit's data is on rd_data now
            rd_pipe_q    <= (rd_pipe_q << 1) | RD_LATENCY'(read_q);
            rdat_valid_q <= rd_pipe_q[RD_LATENCY-1];
            if (rd_pipe_q[RD_LATENCY-1]) begin
                rdat_q <= bus.rd_data;
            end

            case (state_q)
                IDLE: begin
                    // done_q high means this is the done cycle, where a new command is refused
                    if (bus.cmd_start && !done_q) begin
                        ptr_q  <= bus.cmd_base;
                        rem_q  <= bus.cmd_len;
                        busy_q <= 1'b1;
                        if (bus.cmd_len == '0) begin
                            state_q <= DONE;
                        end else if (bus.cmd_write) begin
                            state_q <= WR_BURST;
                        end else begin
                            state_q <= RD_ISSUE;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (wr_xfer) begin
                        cs_q      <= 1'b1;
                        write_q   <= 1'b1;
                        addr_q    <= ptr_q;
                        wr_data_q <= bus.wdat;
                        ptr_q     <= ptr_q + 1'b1;
                        rem_q     <= rem_q - 1'b1;
                        if (last_word) begin
                            state_q <= DONE;
                        end
                    end
                end
                RD_ISSUE: begin
                    cs_q   <= 1'b1;
                    read_q <= 1'b1;
                    addr_q <= ptr_q;
                    ptr_q  <= ptr_q + 1'b1;
                    rem_q  <= rem_q - 1'b1;
                    if (last_word) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (!read_q && (rd_pipe_q == '0)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wdat_ready = wr_rdy;
    assign bus.rdat       = rdat_q;
    assign bus.rdat_valid = rdat_valid_q;
    assign bus.cs         = cs_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_slot_burst_initiator.sv
// Bench for slot_burst_initiator: table of burst commands against a 2-cycle slot RAM model,
// scoreboard queues for slot writes, read addresses and returned data, plus a mid-burst reset sequence.
module tb_slot_burst_initiator;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;

    always #5 clk = ~clk;

    slot_burst_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    slot_burst_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'h5100_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // slot RAM responder: read data valid two cycles after cs&read
    logic [31:0] slot_mem [32];
    logic [31:0] rd_stg;
    logic [31:0] rd_data_r;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) slot_mem[i] <= init_val(i);
        end else if (bus.cs && bus.write) begin
            slot_mem[bus.addr] <= bus.wr_data;
        end
        rd_stg    <= (bus.cs && bus.read) ? slot_mem[bus.addr] : 32'hDEAD_BEEF;
        rd_data_r <= rd_stg;
    end
    assign bus.rd_data = rd_data_r;

    typedef struct {
        logic        wr;
        int          base;
        int          len;
        logic [15:0] vpat;
        int          inj;
        int          exp_ops;
        int          exp_last;
        int          exp_span;
        int          exp_done_k;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [4:0]  raq[$];
    logic [31:0] rq[$];
    logic [31:0] exp_mem [32];

    int checks = 0;
    int errors = 0;
    int cyc, ops, first_op, last_op, rv_cnt, first_rv, last_rv, done_cnt, done_k, busy_cycles;
    logic [4:0]  last_addr;
    logic        s_rdy, s_cs, s_busy;
    logic [31:0] s_rdat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_counters();
        ops = 0; first_op = -1; last_op = -1;
        rv_cnt = 0; first_rv = -1; last_rv = -1;
        done_cnt = 0; done_k = -1; busy_cycles = 0;
        wq.delete(); raq.delete(); rq.delete();
    endtask

    // observe one cycle at the falling edge, then step past the next rising edge
    task automatic sample();
        wr_t e;
        logic [4:0] ea;
        @(negedge clk);
        s_rdy = bus.wdat_ready; s_cs = bus.cs; s_busy = bus.busy; s_rdat = bus.rdat;
        if (cyc >= 1 && bus.busy) busy_cycles++;
        chk("protocol", 32'((bus.read && bus.write) || ((bus.read || bus.write) && !bus.cs)), 0);
        if (bus.cs && (bus.write || bus.read)) begin
            ops++; last_addr = bus.addr;
            if (first_op < 0) first_op = cyc;
            last_op = cyc;
        end
        if (bus.cs && bus.write) begin
            if (wq.size() == 0) chk("unexpected_write", 32'(bus.addr), 32'hFFFF_FFFF);
            else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(bus.addr), 32'(e.a));
                chk("wr_data", bus.wr_data, e.d);
            end
        end
        if (bus.cs && bus.read) begin
            if (raq.size() == 0) chk("unexpected_read", 32'(bus.addr), 32'hFFFF_FFFF);
            else begin
                ea = raq.pop_front();
                chk("rd_addr", 32'(bus.addr), 32'(ea));
            end
        end
        if (bus.rdat_valid) begin
            rv_cnt++;
            if (first_rv < 0) first_rv = cyc;
            last_rv = cyc;
            if (rq.size() == 0) chk("unexpected_rdat", bus.rdat, 32'hFFFF_FFFF);
            else chk("rdat", bus.rdat, rq.pop_front());
        end
        if (bus.done) begin
            done_cnt++; done_k = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        logic [31:0] wd[$];
        logic [4:0]  a;
        logic [31:0] d;
        logic        vld;
        int          idx;
        reset_counters();
        for (int i = 0; i < v.len; i++) begin
            a = 5'((v.base + i) % 32);
            if (v.wr) begin
                d = 32'hA0 + 32'(i) + (32'(vi) << 16);
                wd.push_back(d);
                wq.push_back('{a, d});
                exp_mem[a] = d;
            end else begin
                raq.push_back(a);
                rq.push_back(exp_mem[a]);
            end
        end
        bus.cmd_write = v.wr; bus.cmd_base = 5'(v.base); bus.cmd_len = 6'(v.len);
        bus.cmd_start = 1'b1;
        cyc = 0;
        sample();
        bus.cmd_start = 1'b0;
        idx = 0;
        for (int k = 1; k < 400; k++) begin
            if (done_cnt > 0 && k > done_k + 4) break;
            cyc = k;
            if (k == v.inj) begin
                bus.cmd_start = 1'b1; bus.cmd_base = 5'(v.base + 13);
                bus.cmd_len = 6'd5; bus.cmd_write = ~v.wr;
            end
            vld = v.wr && done_cnt == 0 && idx < v.len && v.vpat[4'((k - 1) % 16)];
            bus.wdat_valid = vld;
            bus.wdat = vld ? wd[idx] : 32'hBAD0_0000;
            sample();
            if (vld && s_rdy) idx++;
            bus.cmd_start = 1'b0; bus.wdat_valid = 1'b0;
        end
        chk("done_count", done_cnt, 1);
        chk("done_latency", done_k, v.exp_done_k);
        chk("busy_cycles", busy_cycles, v.exp_done_k);
        chk("busy_after", 32'(s_busy), 0);
        chk("slot_ops", ops, v.exp_ops);
        if (v.exp_ops > 0) chk("last_addr", 32'(last_addr), v.exp_last);
        if (v.exp_span >= 0) chk("op_span", last_op - first_op, v.exp_span);
        chk("queues_empty", wq.size() + raq.size() + rq.size(), 0);
        if (!v.wr) begin
            chk("rdat_count", rv_cnt, v.len);
            if (v.len > 0) begin
                chk("rd_latency", first_rv - first_op, 3);
                chk("rdat_span", last_rv - first_rv, v.len - 1);
            end
        end
    endtask

    vec_t vecs [9];
    vec_t post [2];

    initial begin
        //          wr    base len  vpat      inj ops last span done_k
        vecs[0] = '{1'b1, 3,   4,  16'hFFFF, 0,  4,  6,   3,   6};
        vecs[1] = '{1'b1, 30,  4,  16'hFFED, 0,  4,  1,   5,   8};
        vecs[2] = '{1'b0, 3,   4,  16'hFFFF, 0,  4,  6,   3,   10};
        vecs[3] = '{1'b0, 5,   32, 16'hFFFF, 0,  32, 4,   31,  38};
        vecs[4] = '{1'b1, 0,   0,  16'hFFFF, 2,  0,  0,   -1,  2};
        vecs[5] = '{1'b1, 8,   3,  16'hFFFF, 2,  3,  10,  2,   5};
        vecs[6] = '{1'b0, 31,  2,  16'hFFFF, 0,  2,  0,   1,   8};
        vecs[7] = '{1'b0, 6,   1,  16'hFFFF, 3,  1,  6,   0,   7};
        vecs[8] = '{1'b0, 0,   0,  16'hFFFF, 0,  0,  0,   -1,  2};
        post[0] = '{1'b1, 17,  1,  16'hFFFF, 0,  1,  17,  0,   3};
        post[1] = '{1'b0, 17,  1,  16'hFFFF, 0,  1,  17,  0,   7};

        for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
        bus.cmd_start = 1'b0; bus.cmd_write = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.wdat = '0; bus.wdat_valid = 1'b0;
        reset = 1'b1; mem_init = 1'b1; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(bus.cs), 0);
        chk("rst_read", 32'(bus.read), 0);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_wdat_ready", 32'(bus.wdat_ready), 0);
        chk("rst_rdat_valid", 32'(bus.rdat_valid), 0);
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_rdat", bus.rdat, 0);
        reset = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // reset lands while the 2nd of 4 reads is on the slot
        reset_counters();
        raq.push_back(5'd0); raq.push_back(5'd1);
        bus.cmd_write = 1'b0; bus.cmd_base = 5'd0; bus.cmd_len = 6'd4; bus.cmd_start = 1'b1;
        cyc = 0;
        sample();
        bus.cmd_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc = k;
            if (k == 3) reset = 1'b1;
            sample();
            reset = 1'b0;
        end
        cyc = 4;
        sample();
        chk("midrst_cs", 32'(s_cs), 0);
        chk("midrst_busy", 32'(s_busy), 0);
        chk("midrst_rdat", s_rdat, 0);
        for (int k = 5; k < 17; k++) begin
            cyc = k;
            sample();
        end
        chk("midrst_no_rdat", rv_cnt, 0);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_reads", ops, 2);
        chk("midrst_queue", raq.size(), 0);

        for (int i = 0; i < 2; i++) run_vec(post[i], 9 + i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
